demux_rr_dispatcher: RTL and testbench

Credit-based round-robin dispatcher that drives the select and data inputs of the 1-to-4 demultiplexer (one-hot `i_sel_code`, data bit `i_a`). It accepts a stream of words on a valid/ready handshake and picks the destination channel for each word. Selection is round-robin among channels that hold a credit. Downstream consumers return credits one at a time. The block sits between the upstream producer and the demux and is the only driver of the demux select lines.

---
 rtl/demux_rr_dispatcher.sv | 157 +++++++++++++++
 tb/tb_demux_rr_dispatcher.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher
// Credit-based round-robin dispatcher feeding a 1-to-4 demux (one-hot select + data).
// Words arrive on a valid/ready handshake. Each word goes to the next channel, in
// round-robin order, that still holds a credit. Consumers return credits one at a time.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_en          dispatch enable (gates accepts only)
//   i_valid       upstream word valid
//   i_data        upstream word
//   o_ready       block can accept a word this cycle (combinational, independent of i_valid)
//   i_credit      per-channel credit-return pulses
//   o_sel_code    registered one-hot demux select (all-zero when idle)
//   o_a           registered word presented to the demux
//   o_valid       o_sel_code/o_a carry a dispatched word this cycle
//   o_credit_err  sticky flag: credit returned to a channel already full
module demux_rr_dispatcher #(
    parameter int unsigned DATA_W     = 1,
    parameter int unsigned CREDIT_MAX = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic [3:0]        i_credit,
    output logic [3:0]        o_sel_code,
    output logic [DATA_W-1:0] o_a,
    output logic              o_valid,
    output logic              o_credit_err
);

    localparam logic [3:0] CMAX = 4'(CREDIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q [4];
    logic [3:0]        cnt_d [4];
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              err_q, err_d;

    logic [3:0]        elig;
    logic [1:0]        g;
    logic              acc;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            elig[k] = (cnt_q[k] != '0);
        end
    end

    assign o_ready = i_en && (|elig);
    assign acc     = i_valid && o_ready;

    // First eligible channel searching ptr, ptr+1, ... (2-bit index wraps mod 4).
    always_comb begin : grant
        logic [1:0] idx;
        logic       found;
        g     = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && elig[idx]) begin
                g     = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin : datapath
        logic dec;
        ptr_d = ptr_q;
        sel_d = '0;
        a_d   = a_q;
        err_d = err_q;
        dec   = 1'b0;
        if (acc) begin
            sel_d = 4'b0001 << g;
            a_d   = i_data;
            ptr_d = g + 2'd1;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            dec      = acc && (g == 2'(k));
            cnt_d[k] = cnt_q[k];
            if (dec && !i_credit[k]) begin
                cnt_d[k] = cnt_q[k] - 4'd1;
            end else if (!dec && i_credit[k]) begin
                // Over-return saturates and latches the error flag.
                if (cnt_q[k] == CMAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + 4'd1;
                end
            end
        end
    end

    always_comb begin : fsm
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (acc)                           state_d = S_SEND;
                else if (i_valid && i_en && !(|elig)) state_d = S_STALL;
                else                               state_d = S_IDLE;
            end
            S_SEND: begin
                if (acc)                      state_d = S_SEND;
                else if (i_valid && !o_ready) state_d = S_STALL;
                else                          state_d = S_IDLE;
            end
            S_STALL: begin
                if (acc)           state_d = S_SEND;
                else if (!i_valid) state_d = S_IDLE;
                else               state_d = S_STALL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            err_q   <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) begin
                cnt_q[k] <= CMAX;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            err_q   <= err_d;
            for (int unsigned k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign o_sel_code   = sel_q;
    assign o_a          = a_q;
    assign o_valid      = (state_q == S_SEND);
    assign o_credit_err = err_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
module tb_demux_rr_dispatcher;

    localparam int CMAX = 3;

    logic       clk;
    logic       i_rst, i_en, i_valid;
    logic [0:0] i_data;
    logic [3:0] i_credit;
    logic       o_ready, o_valid, o_credit_err;
    logic [3:0] o_sel_code;
    logic [0:0] o_a;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel credit counts, rotating pointer, expected outputs.
    int         m_cnt [4];
    int         m_ptr;
    logic [3:0] m_sel;
    logic       m_a;
    logic       m_valid;
    logic       m_err;

    demux_rr_dispatcher #(.DATA_W(1), .CREDIT_MAX(CMAX)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .i_credit     (i_credit),
        .o_sel_code   (o_sel_code),
        .o_a          (o_a),
        .o_valid      (o_valid),
        .o_credit_err (o_credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_cnt[k] = CMAX;
        m_ptr   = 0;
        m_sel   = 4'b0000;
        m_a     = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 i_rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check current outputs vs model, advance model.
    task automatic step(input logic v, input logic d, input logic [3:0] cr, input logic en);
        bit any, rdy, acc;
        int g, n;
        i_valid  = v;
        i_data   = d;
        i_credit = cr;
        i_en     = en;
        #1;
        any = 0;
        for (int k = 0; k < 4; k++) if (m_cnt[k] > 0) any = 1;
        rdy = en && any;
        chk("ready", o_ready, rdy);
        chk("valid", o_valid, m_valid);
        chk("sel",   o_sel_code, m_sel);
        chk("a",     o_a, m_a);
        chk("err",   o_credit_err, m_err);
        for (int k = 0; k < 4; k++) chk($sformatf("cnt%0d", k), dut.cnt_q[k], m_cnt[k]);
        acc = v && rdy;
        g = -1;
        for (int i = 0; i < 4; i++) begin
            if (g < 0 && m_cnt[(m_ptr + i) % 4] > 0) g = (m_ptr + i) % 4;
        end
        m_valid = acc;
        if (acc) begin
            m_sel = 4'(1 << g);
            m_a   = d;
            m_ptr = (g + 1) % 4;
        end else begin
            m_sel = 4'b0000;
        end
        for (int k = 0; k < 4; k++) begin
            n = m_cnt[k] + (cr[k] ? 1 : 0) - ((acc && g == k) ? 1 : 0);
            if (n > CMAX) begin
                n     = CMAX;
                m_err = 1'b1;
            end
            m_cnt[k] = n;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_data;
        i_rst = 1'b1; i_en = 1'b0; i_valid = 1'b0; i_data = '0; i_credit = '0;
        model_reset();
        @(posedge clk);
        #1 i_rst = 1'b0;

        // Reset state: o_ready follows i_en
        step(0, 0, 4'b0000, 0);
        chk("rst_ready_en0", o_ready, 1'b0);
        step(0, 0, 4'b0000, 1);

        // Round-robin: data 1,0,1,1 to channels 0..3
        rr_data = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step(1, rr_data[i], 4'b0000, 1);
            chk("rr_sel", o_sel_code, 32'(1 << i));
            chk("rr_a", o_a, rr_data[i]);
        end
        // Exhaust the remaining 8 credits
        for (int i = 0; i < 8; i++) step(1, 1'($urandom), 4'b0000, 1);
        chk("exh_ready", o_ready, 1'b0);
        for (int i = 0; i < 3; i++) step(1, 0, 4'b0000, 1);
        chk("exh_stall_valid", o_valid, 1'b0);

        // Credit return to channel 2 unblocks exactly one word
        step(1, 1, 4'b0100, 1);
        chk("unblk_ready", o_ready, 1'b1);
        step(1, 1, 4'b0000, 1);
        chk("unblk_sel", o_sel_code, 4'b0100);
        chk("reblock_ready", o_ready, 1'b0);
        step(1, 0, 4'b0000, 1);

        // Skip empty channel 1 with ptr = 1
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 0, 4'b0000, 1);
        step(0, 0, 4'b1101, 1);
        step(1, 1, 4'b0000, 1);
        chk("skip_first", o_sel_code, 4'b0001);
        step(1, 0, 4'b0000, 1);
        chk("skip_sel", o_sel_code, 4'b0100);
        step(0, 0, 4'b0000, 1);

        // Simultaneous decrement/return, then overflow
        do_reset();
        step(1, 1, 4'b0001, 1);
        chk("simul_cnt0", dut.cnt_q[0], 4'd3);
        chk("simul_err", o_credit_err, 1'b0);
        step(0, 0, 4'b0010, 1);
        chk("ovf_err", o_credit_err, 1'b1);
        for (int i = 0; i < 10; i++) step(0, 0, 4'b0000, 1);
        chk("ovf_err_sticky", o_credit_err, 1'b1);

        // Async reset in the middle of an S_SEND cycle
        step(1, 1, 4'b0000, 1);
        step(1, 1, 4'b0000, 1);
        chk("pre_rst_valid", o_valid, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", o_valid, 1'b0);
        chk("arst_sel", o_sel_code, 4'b0000);
        chk("arst_err", o_credit_err, 1'b0);
        model_reset();
        @(posedge clk);
        #1 i_rst = 1'b0;
        step(1, 1, 4'b0000, 1);
        chk("post_rst_sel", o_sel_code, 4'b0001);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 4'($urandom & $urandom & $urandom), $urandom_range(0, 7) != 0);
            chk("onehot", 32'($countones(o_sel_code) <= 1), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
